// File: rtl/audio_pkg.sv
// Shared audio-path definitions: I2S frame geometry and the stereo sample type
// passed between the mixer, the filter and the I2S transmitter.
package audio_pkg;

  localparam int I2S_FRAME_BITS = 64;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int MCLK_PER_SCLK  = 4;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_frame_tx_if.sv
// Valid/ready stereo sample stream feeding the I2S transmitter.
interface i2s_frame_tx_if #(
  parameter int DW = 16
);

  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_left;
  logic signed [DW-1:0] s_right;

  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave  (input s_valid, s_left, s_right, output s_ready);

endinterface

// File: rtl/i2s_frame_tx.sv
// Standard I2S transmitter on audio_mclk: SCLK = MCLK/4, 64 SCLK per frame,
// one-deep sample buffer, underrun repeat of the last sample, mute and underrun counter.
module i2s_frame_tx
  import audio_pkg::*;
#(
  parameter int DW     = 16,
  parameter int UCNT_W = 16
) (
  input  logic              audio_mclk,
  input  logic              reset_n,
  i2s_frame_tx_if.slave     s_bus,
  input  logic              mute,
  output logic              audio_sclk,
  output logic              audio_lrck,
  output logic              audio_dac,
  output logic              frame_strobe,
  output logic [UCNT_W-1:0] underrun_cnt
);

  localparam int DIV_W = $clog2(MCLK_PER_SCLK);
  localparam int BIT_W = $clog2(I2S_FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_SCLK - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(I2S_FRAME_BITS - 1);

  if (DW > I2S_SLOT_BITS - 1) begin : g_dw_check
    $error("i2s_frame_tx: DW must leave room for the one-bit I2S delay in a 32-bit slot");
  end

  logic [DIV_W-1:0]     div;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_nxt;
  logic                 edge_e;
  logic                 load;
  logic                 accept;
  logic                 pend_valid;
  logic                 primed;
  logic                 have_new;
  logic signed [DW-1:0] pend_l, pend_r;
  logic signed [DW-1:0] frame_l, frame_r;
  logic signed [DW-1:0] last_l, last_r;
  logic signed [DW-1:0] src_l, src_r;
  logic [DW:0]          slot_word;
  logic                 dac_nxt;

  assign edge_e     = (div == DIV_LAST);
  assign load       = edge_e && (bit_cnt == BIT_LAST);
  assign bit_nxt    = bit_cnt + 1'b1;
  assign audio_sclk = div[DIV_W-1];

  assign s_bus.s_ready = !pend_valid;
  assign accept        = s_bus.s_valid && !pend_valid;

  // Frame source at load: pending pair first, then a same-cycle bypass, else repeat.
  always_comb begin
    src_l    = last_l;
    src_r    = last_r;
    have_new = 1'b0;
    if (pend_valid) begin
      src_l    = pend_l;
      src_r    = pend_r;
      have_new = 1'b1;
    end else if (s_bus.s_valid) begin
      src_l    = s_bus.s_left;
      src_r    = s_bus.s_right;
      have_new = 1'b1;
    end
  end

  // A zero guard bit above the word makes slot position 0 (the I2S delay bit)
  // and positions past the LSB shift out as zero without any range compare.
  always_comb begin
    slot_word = {1'b0, (bit_nxt[BIT_W-1] ? frame_r : frame_l)} << bit_nxt[BIT_W-2:0];
    dac_nxt   = slot_word[DW];
  end

  always_ff @(posedge audio_mclk) begin
    if (!reset_n) begin
      div          <= '0;
      bit_cnt      <= BIT_LAST;
      audio_lrck   <= 1'b0;
      audio_dac    <= 1'b0;
      frame_strobe <= 1'b0;
      underrun_cnt <= '0;
      pend_valid   <= 1'b0;
      primed       <= 1'b0;
      pend_l       <= '0;
      pend_r       <= '0;
      frame_l      <= '0;
      frame_r      <= '0;
      last_l       <= '0;
      last_r       <= '0;
    end else begin
      div          <= div + 1'b1;
      frame_strobe <= load;

      if (edge_e) begin
        bit_cnt    <= bit_nxt;
        audio_lrck <= bit_nxt[BIT_W-1];
        audio_dac  <= dac_nxt;
      end

      if (load) begin
        frame_l <= mute ? '0 : src_l;
        frame_r <= mute ? '0 : src_r;
        if (have_new) begin
          last_l     <= src_l;
          last_r     <= src_r;
          primed     <= 1'b1;
          pend_valid <= 1'b0;
        end else if (primed && (underrun_cnt != '1)) begin
          underrun_cnt <= underrun_cnt + 1'b1;
        end
      end else if (accept) begin
        pend_l     <= s_bus.s_left;
        pend_r     <= s_bus.s_right;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule
